// File: rtl/arb_pkg.sv
// Shared types and helpers for the grant payload buffer.
// Lowest-set-bit index and the default-width entry layout.
package arb_pkg;

  localparam int MAXN   = 64;
  localparam int DEF_W  = 32;
  localparam int DEF_SW = 2;

  typedef struct packed {
    logic [DEF_W-1:0]  payload;
    logic [DEF_SW-1:0] src;
  } entry_t;

  function automatic int onehot_to_idx(
    input logic [MAXN-1:0] v
  );
    int idx;
    idx = 0;
    for (int i = MAXN-1; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO with 1-bit wrapping pointers.
// Head entry is read straight from storage registers.
module skid_fifo2 #(
  parameter int EW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic          pop,
  input  logic [EW-1:0] din,
  output logic [EW-1:0] dout,
  output logic [1:0]    count
);

  logic [EW-1:0] mem_q [2];
  logic          wptr_q, wptr_d;
  logic          rptr_q, rptr_d;
  logic [1:0]    cnt_q, cnt_d;

  always_comb begin
    wptr_d = push ? ~wptr_q : wptr_q;
    rptr_d = pop  ? ~rptr_q : rptr_q;
    cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) mem_q[wptr_q] <= din;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout  = mem_q[rptr_q];
  assign count = cnt_q;

endmodule

// File: rtl/grant_payload_buffer.sv
// Captures the granted requester's payload into a 2-deep FIFO.
// Define GRANT_CHECK_EN to flag and block malformed grants.
module grant_payload_buffer
  import arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 32,
  parameter int CW = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N-1:0]         grant,
  input  logic                 grant_valid,
  input  logic [N*W-1:0]       data_in,
  output logic [N-1:0]         ack,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_data,
  output logic [$clog2(N)-1:0] out_src,
  output logic [CW-1:0]        stall_cnt,
  output logic                 err
);

  localparam int SW = $clog2(N);

  typedef struct packed {
    logic [W-1:0]  payload;
    logic [SW-1:0] src;
  } ent_t;

  localparam int EW = $bits(ent_t);

  logic [1:0]    count;
  logic          push;
  logic          pop;
  logic          gerr;
  logic [N-1:0]  sel_oh;
  logic [SW-1:0] sel_idx;
  ent_t          din;
  ent_t          dout;
  logic [CW-1:0] stall_q, stall_d;

  assign sel_idx = SW'(onehot_to_idx(MAXN'(grant)));
  assign sel_oh  = grant & (~grant + N'(1));

`ifdef GRANT_CHECK_EN
  assign gerr = (|(grant & (grant - N'(1))))
              | (grant_valid != (|grant));
`else
  assign gerr = 1'b0;
`endif

  assign pop  = out_valid & out_ready;
  assign push = rstn & grant_valid
              & (~count[1] | pop) & ~gerr;
  assign ack  = push ? sel_oh : '0;

  assign din.payload = data_in[sel_idx*W +: W];
  assign din.src     = sel_idx;

  skid_fifo2 #(
    .EW(EW)
  ) u_fifo (
    .clk  (clk),
    .rstn (rstn),
    .push (push),
    .pop  (pop),
    .din  (din),
    .dout (dout),
    .count(count)
  );

  assign out_valid = (count != 2'd0);
  assign out_data  = dout.payload;
  assign out_src   = dout.src;

  always_comb begin
    stall_d = stall_q;
    if (grant_valid && !push && stall_q != '1)
      stall_d = stall_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;

`ifdef GRANT_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     err_q <= 1'b0;
    else if (gerr) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_grant_payload_buffer.sv
// Directed bench for grant_payload_buffer.
// Expected values are hand-derived per step.
module tb_grant_payload_buffer;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int CW = 16;

  logic           clk;
  logic           rstn;
  logic [N-1:0]   grant;
  logic           grant_valid;
  logic [N*W-1:0] data_in;
  logic [N-1:0]   ack;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_src;
  logic [CW-1:0]  stall_cnt;
  logic           err;

  int checks   = 0;
  int failures = 0;
  int exp_stall;

  grant_payload_buffer #(
    .N (N),
    .W (W),
    .CW(CW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .grant      (grant),
    .grant_valid(grant_valid),
    .data_in    (data_in),
    .ack        (ack),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_src    (out_src),
    .stall_cnt  (stall_cnt),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] req
  );
    checks++;
    assert (obs === req) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn        = 1'b0;
    grant       = 4'b0100;
    grant_valid = 1'b1;
    out_ready   = 1'b1;
    for (int i = 0; i < N; i++)
      data_in[i*W +: W] = 32'hA5A5_0000 + 32'(i);

    // reset state, with a live grant held on the inputs
    #3;
    chk("rst_ack",   32'(ack),       32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data",  out_data,       32'h0);
    chk("rst_src",   32'(out_src),   32'h0);
    chk("rst_stall", 32'(stall_cnt), 32'h0);
    chk("rst_err",   32'(err),       32'h0);
    grant       = '0;
    grant_valid = 1'b0;
    #9 rstn = 1'b1;

    // single capture, one-cycle latency
    tick();
    grant       = 4'b0100;
    grant_valid = 1'b1;
    #1 chk("t1_ack", 32'(ack), 32'h4);
    tick();
    chk("t1_valid", 32'(out_valid), 32'h1);
    chk("t1_data",  out_data,       32'hA5A5_0002);
    chk("t1_src",   32'(out_src),   32'h2);
    grant       = '0;
    grant_valid = 1'b0;
    #1 chk("t1_ack0", 32'(ack), 32'h0);
    tick();
    chk("t1_drain", 32'(out_valid), 32'h0);

    // fill with ready low, third grant stalls
    out_ready   = 1'b0;
    grant       = 4'b0001;
    grant_valid = 1'b1;
    #1 chk("t2_ack0", 32'(ack), 32'h1);
    tick();
    grant = 4'b0010;
    #1 chk("t2_ack1", 32'(ack), 32'h2);
    tick();
    grant = 4'b1000;
    #1 chk("t2_ack3", 32'(ack), 32'h0);
    tick();
    chk("t2_stall", 32'(stall_cnt), 32'h1);
    grant       = '0;
    grant_valid = 1'b0;
    chk("t2_src",  32'(out_src), 32'h0);
    chk("t2_data", out_data,     32'hA5A5_0000);
    tick();
    tick();
    chk("t2_hold_src",  32'(out_src), 32'h0);
    chk("t2_hold_data", out_data,     32'hA5A5_0000);

    // push while full and popping
    out_ready   = 1'b1;
    grant       = 4'b1000;
    grant_valid = 1'b1;
    #1 chk("t3_ack", 32'(ack), 32'h8);
    tick();
    grant       = '0;
    grant_valid = 1'b0;
    chk("t3_valid1", 32'(out_valid), 32'h1);
    chk("t3_src1",   32'(out_src),   32'h1);
    tick();
    chk("t3_valid3", 32'(out_valid), 32'h1);
    chk("t3_src3",   32'(out_src),   32'h3);
    chk("t3_data3",  out_data,       32'hA5A5_0003);
    tick();
    chk("t3_empty", 32'(out_valid), 32'h0);
    chk("t3_stall", 32'(stall_cnt), 32'h1);

    // multi-hot grant
    grant       = 4'b0011;
    grant_valid = 1'b1;
`ifdef GRANT_CHECK_EN
    #1 chk("mh_ack", 32'(ack), 32'h0);
    tick();
    grant       = '0;
    grant_valid = 1'b0;
    chk("mh_err",   32'(err),       32'h1);
    chk("mh_valid", 32'(out_valid), 32'h0);
    exp_stall = 2;
`else
    #1 chk("mh_ack", 32'(ack), 32'h1);
    tick();
    grant       = '0;
    grant_valid = 1'b0;
    chk("mh_valid", 32'(out_valid), 32'h1);
    chk("mh_src",   32'(out_src),   32'h0);
    chk("mh_data",  out_data,       32'hA5A5_0000);
    chk("mh_err",   32'(err),       32'h0);
    exp_stall = 1;
`endif
    chk("mh_stall", 32'(stall_cnt), 32'(exp_stall));
    tick();
    chk("mh_empty", 32'(out_valid), 32'h0);
    chk("mh_err_hold", 32'(err), 32'(exp_stall - 1));

    // stall counter growth and saturation
    out_ready   = 1'b0;
    grant       = 4'b0100;
    grant_valid = 1'b1;
    tick();
    grant = 4'b0010;
    tick();
    grant = 4'b0001;
    repeat (10) @(posedge clk);
    #1 chk("sat_step", 32'(stall_cnt), 32'(exp_stall + 10));
    repeat (70000) @(posedge clk);
    #1 chk("sat_max", 32'(stall_cnt), 32'hFFFF);
    chk("sat_src", 32'(out_src), 32'h2);

    // async reset while full, no clock edge
    #2 rstn = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'h0);
    chk("ar_stall", 32'(stall_cnt), 32'h0);
    chk("ar_data",  out_data,       32'h0);
    chk("ar_ack",   32'(ack),       32'h0);
    chk("ar_err",   32'(err),       32'h0);
    grant       = '0;
    grant_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    tick();
    chk("ar_post_valid", 32'(out_valid), 32'h0);

    // fresh push after reset, no stale entries
    out_ready   = 1'b1;
    grant       = 4'b1000;
    grant_valid = 1'b1;
    #1 chk("pr_ack", 32'(ack), 32'h8);
    tick();
    grant       = '0;
    grant_valid = 1'b0;
    chk("pr_valid", 32'(out_valid), 32'h1);
    chk("pr_src",   32'(out_src),   32'h3);
    tick();
    chk("pr_empty", 32'(out_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
